// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter: one shared slave, NUM_MASTERS requesters.
// Define WB_ARBITER_PRIORITY_EN to make master 0 win every arbitration it requests.
//
// state | meaning
// IDLE  | no owner, all masters stalled, arbitrating on m_cyc_i
// GRANT | owner forwarded to the slave, outstanding strobes tracked
// DRAIN | owner dropped cyc with strobes unacked; late acks are swallowed
module wb_arbiter #(
    parameter int NUM_MASTERS     = 3,
    parameter int ADDR_WIDTH      = 17,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 3
) (
    input  logic                              wb_clock_i,
    input  logic                              wb_reset_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_stall_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_stall_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int         IW      = (NUM_MASTERS > 2) ? 2 : 1;
    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          r_last;
    logic [1:0]             r_count;

    logic [IW-1:0]          w_sel;
    logic                   w_found;
    logic [1:0]             w_count_nxt;
    logic                   w_full;
    logic                   w_stb;
    logic                   w_accept;

    assign grant_o  = r_grant;
    assign m_dat_o  = s_dat_i;
    assign w_full   = (r_count == MAX_CNT);
    assign s_cyc_o  = (r_state != IDLE);
    assign w_stb    = (r_state == GRANT) && m_stb_i[r_owner] && !w_full;
    assign s_stb_o  = w_stb;
    assign s_we_o   = (r_state == GRANT) && m_we_i[r_owner];
    assign s_adr_o  = m_adr_i[int'(r_owner)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_dat_o  = m_dat_i[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
    assign w_accept = w_stb && !s_stall_i;

    always_comb begin
        m_stall_o = '1;
        m_ack_o   = '0;
        if (r_state == GRANT) begin
            m_stall_o[r_owner] = s_stall_i | w_full;
            m_ack_o[r_owner]   = s_ack_i;
        end
    end

    // Acks arriving with nothing outstanding are ignored rather than wrapping.
    always_comb begin
        w_count_nxt = r_count;
        if (r_state == GRANT) begin
            if (w_accept && !s_ack_i)
                w_count_nxt = r_count + 2'd1;
            else if (!w_accept && s_ack_i && r_count != 2'd0)
                w_count_nxt = r_count - 2'd1;
        end else if (r_state == DRAIN) begin
            if (s_ack_i && r_count != 2'd0)
                w_count_nxt = r_count - 2'd1;
        end
    end

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
`ifdef WB_ARBITER_PRIORITY_EN
        if (m_cyc_i[0]) w_found = 1'b1;
`endif
        for (int i = 1; i <= NUM_MASTERS; i++) begin
`ifdef WB_ARBITER_PRIORITY_EN
            if (!w_found && ((int'(r_last) + i) % NUM_MASTERS) != 0 &&
                m_cyc_i[(int'(r_last) + i) % NUM_MASTERS]) begin
`else
            if (!w_found && m_cyc_i[(int'(r_last) + i) % NUM_MASTERS]) begin
`endif
                w_sel   = IW'((int'(r_last) + i) % NUM_MASTERS);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
            r_count <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_count <= 2'd0;
                    if (w_found) begin
                        r_owner <= w_sel;
                        r_grant <= NUM_MASTERS'(1) << w_sel;
                        r_state <= GRANT;
`ifdef WB_ARBITER_PRIORITY_EN
                        if (w_sel != '0) r_last <= w_sel;
`else
                        r_last  <= w_sel;
`endif
                    end
                end
                GRANT: begin
                    r_count <= w_count_nxt;
                    if (!m_cyc_i[r_owner]) begin
                        if (w_count_nxt == 2'd0) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                            r_owner <= '0;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_count <= w_count_nxt;
                    if (w_count_nxt == 2'd0) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_owner <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single read, rotation, outstanding limit,
// drain after abort and asynchronous reset mid-tenure.
module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 17;
    localparam int DW = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_stall_o, grant_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_stall_i;

    int checks   = 0;
    int failures = 0;

    wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(3)) dut (
        .wb_clock_i(clk),
        .wb_reset_i(rst),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_we_i    (m_we),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat_w),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_stall_o (m_stall_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_stall_i (s_stall_i),
        .grant_o   (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        m_cyc     = '0;
        m_stb     = '0;
        m_we      = '0;
        m_adr     = '0;
        m_dat_w   = '0;
        s_dat_i   = '0;
        s_ack_i   = 1'b0;
        s_stall_i = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (grant_o !== 3'b000) begin
            failures++; $display("FAIL reset_grant: got %b want 000", grant_o);
        end
        checks++;
        if (m_stall_o !== 3'b111) begin
            failures++; $display("FAIL reset_stall: got %b want 111", m_stall_o);
        end
        checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
            failures++; $display("FAIL reset_slave_ctrl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o});
        end
        checks++;
        if (m_ack_o !== 3'b000) begin
            failures++; $display("FAIL reset_ack: got %b want 000", m_ack_o);
        end
    endtask

    task automatic test_single_read;
        do_reset();
        m_cyc = 3'b010;
        m_stb = 3'b010;
        m_adr[1*AW +: AW] = 17'h00400;
        #1;
        checks++;
        if (grant_o !== 3'b000) begin
            failures++; $display("FAIL single_latency: got %b want 000", grant_o);
        end
        step();
        checks++;
        if (grant_o !== 3'b010) begin
            failures++; $display("FAIL single_grant: got %b want 010", grant_o);
        end
        checks++;
        if (s_stb_o !== 1'b1 || s_cyc_o !== 1'b1) begin
            failures++; $display("FAIL single_stb: got cyc=%b stb=%b want 1 1", s_cyc_o, s_stb_o);
        end
        checks++;
        if (s_adr_o !== 17'h00400) begin
            failures++; $display("FAIL single_adr: got %h want 00400", s_adr_o);
        end
        checks++;
        if (m_stall_o !== 3'b101) begin
            failures++; $display("FAIL single_stall: got %b want 101", m_stall_o);
        end
        step();
        m_stb   = 3'b000;
        m_cyc   = 3'b000;
        s_ack_i = 1'b1;
        s_dat_i = 8'hA5;
        #1;
        checks++;
        if (m_ack_o !== 3'b010) begin
            failures++; $display("FAIL single_ack: got %b want 010", m_ack_o);
        end
        checks++;
        if (m_dat_o !== 8'hA5) begin
            failures++; $display("FAIL single_data: got %h want a5", m_dat_o);
        end
        step();
        s_ack_i = 1'b0;
        #1;
        checks++;
        if (grant_o !== 3'b000 || s_cyc_o !== 1'b0) begin
            failures++; $display("FAIL single_release: got grant=%b cyc=%b want 000 0", grant_o, s_cyc_o);
        end
    endtask

    task automatic test_round_robin;
        int           exp_owner [6];
        logic [N-1:0] req;
        logic [N-1:0] onehot;
`ifdef WB_ARBITER_PRIORITY_EN
        exp_owner = '{0, 0, 0, 1, 2, 1};
`else
        exp_owner = '{0, 1, 2, 0, 1, 2};
`endif
        do_reset();
        for (int t = 0; t < 6; t++) begin
            req = 3'b111;
`ifdef WB_ARBITER_PRIORITY_EN
            if (t >= 3) req = 3'b110;
`endif
            m_cyc  = req;
            m_stb  = req;
            onehot = 3'b001 << exp_owner[t];
            step();
            checks++;
            if (grant_o !== onehot) begin
                failures++; $display("FAIL rr_grant[%0d]: got %b want %b", t, grant_o, onehot);
            end
            step();
            s_ack_i = 1'b1;
            m_cyc   = m_cyc & ~onehot;
            m_stb   = m_stb & ~onehot;
            #1;
            checks++;
            if (m_ack_o !== onehot) begin
                failures++; $display("FAIL rr_ack[%0d]: got %b want %b", t, m_ack_o, onehot);
            end
            step();
            s_ack_i = 1'b0;
        end
        idle_inputs();
        step();
    endtask

    task automatic test_outstanding;
        logic [8:0] stb_tab   = 9'b000111111;
        logic [8:0] ack_tab   = 9'b110111000;
        logic [8:0] stall_tab = 9'b000001000;
        do_reset();
        m_cyc   = 3'b001;
        m_we    = 3'b001;
        m_dat_w[0 +: DW] = 8'h3C;
        step();
        checks++;
        if (grant_o !== 3'b001) begin
            failures++; $display("FAIL out_grant: got %b want 001", grant_o);
        end
        for (int c = 0; c < 9; c++) begin
            m_stb   = {2'b00, stb_tab[c]};
            s_ack_i = ack_tab[c];
            if (c == 8) m_cyc = 3'b000;
            #1;
            checks++;
            if (m_stall_o !== {2'b11, stall_tab[c]}) begin
                failures++; $display("FAIL out_stall[%0d]: got %b want %b", c, m_stall_o, {2'b11, stall_tab[c]});
            end
            checks++;
            if (m_ack_o !== {2'b00, ack_tab[c]}) begin
                failures++; $display("FAIL out_ack[%0d]: got %b want %b", c, m_ack_o, {2'b00, ack_tab[c]});
            end
            checks++;
            if (s_stb_o !== (stb_tab[c] & ~stall_tab[c])) begin
                failures++; $display("FAIL out_stb[%0d]: got %b want %b", c, s_stb_o, stb_tab[c] & ~stall_tab[c]);
            end
            if (c == 0) begin
                checks++;
                if (s_we_o !== 1'b1 || s_dat_o !== 8'h3C) begin
                    failures++; $display("FAIL out_write: got we=%b dat=%h want 1 3c", s_we_o, s_dat_o);
                end
            end
            step();
        end
        idle_inputs();
        #1;
        checks++;
        if (grant_o !== 3'b000) begin
            failures++; $display("FAIL out_release: got %b want 000", grant_o);
        end
    endtask

    task automatic test_drain;
        do_reset();
        m_cyc = 3'b100;
        m_stb = 3'b100;
        m_adr[2*AW +: AW] = 17'h1ABCD;
        step();
        checks++;
        if (grant_o !== 3'b100) begin
            failures++; $display("FAIL drain_grant: got %b want 100", grant_o);
        end
        m_cyc = 3'b101;
        #1;
        checks++;
        if (m_stall_o !== 3'b011 || s_adr_o !== 17'h1ABCD) begin
            failures++; $display("FAIL drain_owner_path: got stall=%b adr=%h want 011 1abcd", m_stall_o, s_adr_o);
        end
        step();
        step();
        m_cyc = 3'b001;
        m_stb = 3'b000;
        step();
        #1;
        checks++;
        if (s_stb_o !== 1'b0 || s_cyc_o !== 1'b1) begin
            failures++; $display("FAIL drain_bus: got cyc=%b stb=%b want 1 0", s_cyc_o, s_stb_o);
        end
        checks++;
        if (grant_o !== 3'b100 || m_stall_o !== 3'b111) begin
            failures++; $display("FAIL drain_hold: got grant=%b stall=%b want 100 111", grant_o, m_stall_o);
        end
        for (int k = 0; k < 2; k++) begin
            s_ack_i = 1'b1;
            #1;
            checks++;
            if (m_ack_o !== 3'b000) begin
                failures++; $display("FAIL drain_swallow[%0d]: got %b want 000", k, m_ack_o);
            end
            step();
        end
        s_ack_i = 1'b0;
        #1;
        checks++;
        if (grant_o !== 3'b000 || s_cyc_o !== 1'b0) begin
            failures++; $display("FAIL drain_idle: got grant=%b cyc=%b want 000 0", grant_o, s_cyc_o);
        end
        step();
        checks++;
        if (grant_o !== 3'b001) begin
            failures++; $display("FAIL drain_next: got %b want 001", grant_o);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_async_reset;
        do_reset();
        m_cyc = 3'b010;
        m_stb = 3'b010;
        step();
        step();
        step();
        #1;
        checks++;
        if (s_cyc_o !== 1'b1 || grant_o !== 3'b010) begin
            failures++; $display("FAIL areset_pre: got cyc=%b grant=%b want 1 010", s_cyc_o, grant_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 3'b000) begin
            failures++; $display("FAIL areset_now: got cyc=%b grant=%b want 0 000", s_cyc_o, grant_o);
        end
        checks++;
        if (m_stall_o !== 3'b111 || s_stb_o !== 1'b0) begin
            failures++; $display("FAIL areset_stall: got stall=%b stb=%b want 111 0", m_stall_o, s_stb_o);
        end
        #1;
        rst = 1'b0;
        idle_inputs();
        m_cyc = 3'b100;
        m_stb = 3'b100;
        step();
        checks++;
        if (grant_o !== 3'b100 || s_stb_o !== 1'b1) begin
            failures++; $display("FAIL areset_regrant: got grant=%b stb=%b want 100 1", grant_o, s_stb_o);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_outstanding();
        test_drain();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin Wishbone B4 pipelined arbiter. It shares one slave port (the shared RAM/BRAM behind wb_mux) among NUM_MASTERS requesters, such as the SPI bridge, video fetch and keyboard scanner.
- Grants the bus for one complete cycle, tracks outstanding transfers, and drains stray acks after an abort so they never reach the wrong master.
- Sits between the requesters and wb_mux.

Parameters:
- NUM_MASTERS, 3, number of requesters (2..4).
- ADDR_WIDTH, 17, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- MAX_OUTSTANDING, 3, maximum accepted-but-unacked strobes (1..3; counter is 2 bits).

Ports:
- wb_clock_i  in  1  system clock.
- wb_reset_i  in  1  asynchronous, active-high reset.
- m_cyc_i  in  NUM_MASTERS  per-master cyc.
- m_stb_i  in  NUM_MASTERS  per-master stb.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- m_stall_o  out  NUM_MASTERS  per-master stall.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control.
- s_adr_o  out  ADDR_WIDTH  slave address.
- s_dat_o  out  DATA_WIDTH  slave write data.
- s_dat_i  in  DATA_WIDTH  slave read data.
- s_ack_i, s_stall_i  in  1 each  slave handshake.
- grant_o  out  NUM_MASTERS  one-hot current owner; all zero when no owner.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, grant_o=0, last=NUM_MASTERS-1, count=0.
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o and s_dat_o follow master 0 (don't-care).
  - m_ack_o=0, m_stall_o=all ones.
- States: IDLE, GRANT, DRAIN.
- IDLE:
  - All m_stall_o=1.
  - If any m_cyc_i is high, select the first requester searching from last+1 modulo NUM_MASTERS.
  - Register grant_o and last, then go to GRANT. Arbitration latency is 1 cycle; the forwarded stb appears at the earliest 1 cycle after cyc rises.
- GRANT, owner g:
  - s_cyc_o=1, s_stb_o=m_stb_i[g]. s_we_o, s_adr_o and s_dat_o are combinational muxes of master g.
  - m_stall_o[g]=s_stall_i | (count==MAX_OUTSTANDING). While count is full, s_stb_o is also forced to 0.
  - m_ack_o[g]=s_ack_i. Every non-owner has stall=1 and ack=0.
  - Outstanding counter:
    - Accept (s_stb_o & ~s_stall_i) adds 1; s_ack_i subtracts 1.
    - Accept and ack in the same cycle leave count unchanged.
    - Underflow (ack while count==0) is ignored; count stays 0.
  - Exit when m_cyc_i[g] falls:
    - count==0, or count==1 with s_ack_i this cycle → IDLE, grant_o=0.
    - Otherwise → DRAIN.
- DRAIN:
  - s_cyc_o=1, s_stb_o=0, all m_ack_o=0, all m_stall_o=1. grant_o stays on g.
  - Each s_ack_i decrements count; late acks are swallowed.
  - When count reaches 0 (including the cycle the final ack arrives), go to IDLE with grant_o=0.
- Fairness: a master that held the bus has lowest priority at the next arbitration. There is no maximum tenure; a master may hold cyc indefinitely.
- Simultaneous cyc rises in IDLE: the round-robin order decides.
- Owner drops cyc and raises it again on the next cycle: goes through IDLE and competes with the others.
- m_dat_o = s_dat_i at all times.

Optional Feature:
- Macro: WB_ARBITER_PRIORITY_EN.
- Defined:
  - Master 0 (video fetch) always wins arbitration in IDLE when its cyc is high.
  - Masters 1..N-1 rotate round-robin among themselves.
  - last is updated only for grants to masters 1..N-1.
- Undefined: pure round-robin across all masters, as above.
- No preemption in either mode.

Test Plan:
- Reset, then master 1 raises cyc with a single read of adr 0x00400. Required:
  - grant_o=3'b010 one cycle later.
  - s_stb_o=1 with s_adr_o=0x00400.
  - Slave acks with s_dat_i=0xA5 → m_ack_o=3'b010, m_dat_o=0xA5.
  - After cyc falls, grant_o=0 and state returns to IDLE.
- All three masters hold cyc continuously, each issuing one transfer per tenure. Required:
  - Grant order 0,1,2,0,1,2 after reset.
  - With WB_ARBITER_PRIORITY_EN defined, the order is 0,0,… while m0 keeps requesting, and 1,2,1,2 once m0 idles.
- Master 0 streams 5 writes with the slave never stalling and acks delayed 2 cycles. Required:
  - count peaks at 3.
  - m_stall_o[0]=1 exactly while count==3.
  - All 5 acks are delivered only to master 0.
- Master 2 issues 2 strobes, then drops cyc before any ack. Required:
  - State=DRAIN, s_stb_o=0, s_cyc_o=1.
  - Two subsequent s_ack_i pulses produce m_ack_o=0.
  - IDLE the cycle after the second ack; a waiting master 0 is granted next.
- Assert wb_reset_i mid-GRANT with count=2. Required:
  - Outputs take their reset values immediately (s_cyc_o=0, grant_o=0, m_stall_o=3'b111) without waiting for a clock edge.
  - After release, the next request is granted normally.
